// File: rtl/runlight_ctrl.sv
// runlight_ctrl: key synchroniser/debouncer, run/direction/speed mode
// registers and the step-strobe generator for the 4-LED running light.
//
// Interface semantics: there is no valid/ready handshake on this block.
// key_pulse[i] and tick are single-cycle strobes; a strobe is "valid" for
// exactly the one cycle it is high and the consumer cannot stall it.
// run_en, dir and speed_sel are registered levels that change only on the
// edge that raises the corresponding key_pulse bit.
module runlight_ctrl #(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int BASE_TICKS = 12_500_000,
    parameter int CNT_W      = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_n,
    output logic [2:0] key_pulse,
    output logic       run_en,
    output logic       dir,
    output logic [1:0] speed_sel,
    output logic       tick
);

    localparam int              DB_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] BASE   = CNT_W'(BASE_TICKS);

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [2:0]       stable_nxt;
    logic [2:0]       press;
    logic [DB_W-1:0]  db_cnt     [3];
    logic [DB_W-1:0]  db_cnt_nxt [3];
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] period_last;
    logic             restart;

    // Two-flop synchroniser for the asynchronous keys; released (1) at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Debounce next state: a key must disagree with its stable level for
    // DB_CYCLES consecutive samples; any agreeing sample restarts the count.
    always_comb begin
        stable_nxt = stable;
        db_cnt_nxt = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (sync2[i] != stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
                end
            end
        end
        // A press is the debounced level falling 1 -> 0 on this edge.
        press = stable & ~stable_nxt;
    end

    // Debounced level and per-key qualification counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '1;
            db_cnt <= '{default: '0};
        end else begin
            stable <= stable_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    // Press strobes and mode registers, all updated on the press edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_pulse <= '0;
            run_en    <= 1'b1;
            dir       <= 1'b0;
            speed_sel <= 2'd1;
        end else begin
            key_pulse <= press;
            if (press[0]) run_en    <= ~run_en;
            if (press[1]) dir       <= ~dir;
            if (press[2]) speed_sel <= speed_sel + 2'd1;
        end
    end

    // Terminal count of the current step period; a run or speed change
    // restarts the period so the new rate takes effect from a clean phase.
    always_comb begin
        period_last = (BASE << speed_sel) - CNT_W'(1);
        restart     = press[0] | press[2];
    end

    // Step counter and the one-cycle tick strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
            tick     <= 1'b0;
        end else if (restart || !run_en) begin
            step_cnt <= '0;
            tick     <= 1'b0;
        end else if (step_cnt == period_last) begin
            step_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            step_cnt <= step_cnt + CNT_W'(1);
            tick     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_runlight_ctrl.sv
// Bench for runlight_ctrl: directed scenarios plus random key activity,
// checked against an event-level reference model through an expected queue.
module tb_runlight_ctrl;

    localparam int DB   = 4;
    localparam int BASE = 3;
    localparam int CW   = 8;
    localparam int W    = 40;   // {cycle[31:0], pulse[2:0], run, dir, spd[1:0], tick}

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic [2:0] key_pulse;
    logic       run_en;
    logic       dir;
    logic [1:0] speed_sel;
    logic       tick;

    always #5 clk = ~clk;

    runlight_ctrl #(.DB_CYCLES(DB), .BASE_TICKS(BASE), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .key_pulse (key_pulse),
        .run_en    (run_en),
        .dir       (dir),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Event-level view: a key's filtered level flips once its synchronised
    // sample has disagreed for DB edges since it last agreed (or since reset
    // or the previous flip). Ticks fall on every multiple of the period
    // measured from the last restart edge.
    logic [2:0] m_d1, m_d2, m_stable;
    int         m_last_agree[3];
    int         m_last_restart;
    logic       m_run, m_dir;
    logic [1:0] m_spd;

    function automatic logic [W-1:0] pack_ev(input int t, input logic [2:0] p,
                                             input logic r, input logic d,
                                             input logic [1:0] s, input logic tk);
        return {32'(t), p, r, d, s, tk};
    endfunction

    task automatic model_edge(input int t);
        logic [2:0] sample;
        logic [2:0] pr;
        logic       tk;
        int         period;
        if (rst) begin
            m_d1 = '1; m_d2 = '1; m_stable = '1;
            for (int i = 0; i < 3; i++) m_last_agree[i] = t;
            m_last_restart = t;
            m_run = 1'b1; m_dir = 1'b0; m_spd = 2'd1;
        end else begin
            sample = m_d2;
            m_d2   = m_d1;
            m_d1   = key_n;
            pr     = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (sample[i] == m_stable[i]) begin
                    m_last_agree[i] = t;
                end else if (t - m_last_agree[i] >= DB) begin
                    m_stable[i]     = sample[i];
                    m_last_agree[i] = t;
                    pr[i]           = ~sample[i];
                end
            end
            period = BASE << m_spd;
            tk = m_run && !(pr[0] || pr[2]) && ((t - m_last_restart) % period == 0);
            if (pr[0]) m_run = ~m_run;
            if (pr[1]) m_dir = ~m_dir;
            if (pr[2]) m_spd = m_spd + 2'd1;
            if (pr[0] || pr[2]) m_last_restart = t;
            if (pr != 3'b000 || tk)
                exp_q.push_back(pack_ev(t, pr, m_run, m_dir, m_spd, tk));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge(cyc + 1);
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic hold(input logic [2:0] k, input int n);
        key_n = k;
        repeat (n) step();
    endtask

    task automatic press_key(input logic [2:0] k, input int gap);
        hold(k, DB + 4);
        hold(3'b111, gap);
    endtask

    task automatic check_state(input string name);
        tests++;
        if ({run_en, dir, speed_sel} !== {m_run, m_dir, m_spd}) begin
            fails++;
            $display("FAIL %s: got run=%b dir=%b spd=%0d, expected run=%b dir=%b spd=%0d",
                     name, run_en, dir, speed_sel, m_run, m_dir, m_spd);
        end
    endtask

    task automatic check_reset(input string name);
        tests++;
        if ({key_pulse, run_en, dir, speed_sel, tick} !== {3'b000, 1'b1, 1'b0, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL %s: got pulse=%b run=%b dir=%b spd=%0d tick=%b, expected pulse=000 run=1 dir=0 spd=1 tick=0",
                     name, key_pulse, run_en, dir, speed_sel, tick);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    always @(negedge clk) begin
        if ((key_pulse != 3'b000) || tick) begin
            mon_got = pack_ev(cyc, key_pulse, run_en, dir, speed_sel, tick);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got cyc=%0d pulse=%b run=%b dir=%b spd=%0d tick=%b, expected no event",
                         cyc, key_pulse, run_en, dir, speed_sel, tick);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d pulse=%b run=%b dir=%b spd=%0d tick=%b, expected cyc=%0d pulse=%b run=%b dir=%b spd=%0d tick=%b",
                             cyc, key_pulse, run_en, dir, speed_sel, tick,
                             mon_exp[39:8], mon_exp[7:5], mon_exp[4], mon_exp[3],
                             mon_exp[2:1], mon_exp[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset and idle ticking at the default speed.
        rst = 1'b1;
        hold(3'b111, 3);
        check_reset("reset_state");
        rst = 1'b0;
        hold(3'b111, 20);
        check_state("idle_after_reset");

        // Short glitch on direction key is rejected, a long hold toggles dir.
        hold(3'b101, $urandom_range(1, DB - 1));
        hold(3'b111, 10);
        check_state("dir_glitch_rejected");
        hold(3'b101, 20);
        hold(3'b111, 10);
        check_state("dir_toggled");

        // Speed cycles 2, 3, 0, 1 with the period restarting on each change.
        for (int n = 0; n < 4; n++) begin
            press_key(3'b011, $urandom_range(20, 40));
            check_state("speed_step");
        end

        // Pause for a while, then resume.
        press_key(3'b110, 50);
        check_state("paused");
        press_key(3'b110, 20);
        check_state("resumed");

        // Pause and speed keys pressed together.
        hold(3'b010, 10);
        hold(3'b111, 10);
        check_state("simultaneous_keys");
        press_key(3'b110, 15);

        // Reset while the direction key is held; held key counts as fresh press.
        hold(3'b101, 3);
        rst = 1'b1;
        step();
        check_reset("reset_mid_run");
        rst = 1'b0;
        hold(3'b101, 12);
        hold(3'b111, 10);
        check_state("press_after_reset");

        // Random key activity including glitches and overlapping presses.
        for (int n = 0; n < 60; n++) begin
            hold(3'($urandom_range(0, 7)), $urandom_range(1, 12));
        end
        hold(3'b111, 30);
        check_state("after_random");

        // Every predicted event must have been observed.
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unobserved events, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
